// File: rtl/scheduler.sv
// Round-robin thread scheduler: each clock, grants the next active thread after the
// last one granted (wrapping) and presents its ID and a valid flag as registered outputs.
module scheduler #(
  parameter int NUM_THREADS     = 4,
  parameter int THREAD_ID_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_THREADS-1:0]     active_threads,
  output logic [THREAD_ID_WIDTH-1:0] scheduled_thread,
  output logic                       scheduled_valid
);

  localparam int PTR_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic [PTR_W-1:0]           r_last_ptr;
  logic [THREAD_ID_WIDTH-1:0] r_thread;
  logic                       r_valid;

  logic [PTR_W:0]             w_sum;
  logic [PTR_W-1:0]           w_cand;
  logic                       w_found;
  logic [PTR_W-1:0]           w_winner;
  logic [THREAD_ID_WIDTH-1:0] w_winner_ext;

  // Search runs from the farthest offset down to the nearest, so the nearest hit wins;
  // the compare-and-subtract wrap keeps IDs in range for non-power-of-two counts.
  always_comb begin
    w_sum    = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = NUM_THREADS; i >= 1; i--) begin
      w_sum  = {1'b0, r_last_ptr} + (PTR_W+1)'(i);
      w_sum  = (w_sum >= (PTR_W+1)'(NUM_THREADS)) ? (w_sum - (PTR_W+1)'(NUM_THREADS)) : w_sum;
      w_cand = w_sum[PTR_W-1:0];
      w_winner = active_threads[w_cand] ? w_cand : w_winner;
      w_found  = active_threads[w_cand] | w_found;
    end
  end

  // Zero-extend the winner to the output ID width.
  always_comb begin
    w_winner_ext = '0;
    w_winner_ext[PTR_W-1:0] = w_winner;
  end

  // Grant register and last-granted pointer; an empty mask holds the ID and drops valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_ptr <= PTR_W'(NUM_THREADS - 1);
      r_thread   <= '0;
      r_valid    <= 1'b0;
    end else if (w_found) begin
      r_last_ptr <= w_winner;
      r_thread   <= w_winner_ext;
      r_valid    <= 1'b1;
    end else begin
      r_last_ptr <= r_last_ptr;
      r_thread   <= r_thread;
      r_valid    <= 1'b0;
    end
  end

  assign scheduled_thread = r_thread;
  assign scheduled_valid  = r_valid;

endmodule

// File: tb/tb_scheduler.sv
// Directed bench for the round-robin scheduler: a 4-thread instance and a 5-thread
// instance, with hand-computed grant sequences compared after every clock edge.
module tb_scheduler;

  logic       clk = 1'b0;
  logic       reset4;
  logic [3:0] active4;
  logic [2:0] thread4;
  logic       valid4;
  logic       reset5;
  logic [4:0] active5;
  logic [2:0] thread5;
  logic       valid5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scheduler #(.NUM_THREADS(4), .THREAD_ID_WIDTH(3)) u_dut4 (
    .clk              (clk),
    .reset            (reset4),
    .active_threads   (active4),
    .scheduled_thread (thread4),
    .scheduled_valid  (valid4)
  );

  scheduler #(.NUM_THREADS(5), .THREAD_ID_WIDTH(3)) u_dut5 (
    .clk              (clk),
    .reset            (reset5),
    .active_threads   (active5),
    .scheduled_thread (thread5),
    .scheduled_valid  (valid5)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a mask to the 4-thread instance for one edge and compare the grant.
  task automatic step4(input string tag, input logic [3:0] mask, input int exp_thr, input int exp_vld);
    active4 = mask;
    tick();
    check_val({tag, ".thr"}, int'(thread4), exp_thr);
    check_val({tag, ".vld"}, int'(valid4), exp_vld);
  endtask

  task automatic step5(input string tag, input logic [4:0] mask, input int exp_thr);
    active5 = mask;
    tick();
    check_val({tag, ".thr"}, int'(thread5), exp_thr);
    check_val({tag, ".vld"}, int'(valid5), 1);
    check_val({tag, ".range"}, int'(thread5 < 3'd5), 1);
  endtask

  initial begin
    reset4  = 1'b1;
    reset5  = 1'b1;
    active4 = 4'b1111;
    active5 = 5'b11111;
    #1;

    // Reset state on both instances.
    tick();
    check_val("rst4.thr", int'(thread4), 0);
    check_val("rst4.vld", int'(valid4), 0);
    check_val("rst5.thr", int'(thread5), 0);
    check_val("rst5.vld", int'(valid5), 0);

    // All-active rotation with wrap.
    reset4 = 1'b0;
    step4("all0", 4'b1111, 0, 1);
    step4("all1", 4'b1111, 1, 1);
    step4("all2", 4'b1111, 2, 1);
    step4("all3", 4'b1111, 3, 1);
    step4("all4", 4'b1111, 0, 1);

    // Shrinking masks, last-candidate regrant, then wrap.
    step4("shr0", 4'b1110, 1, 1);
    step4("shr1", 4'b1101, 2, 1);
    step4("shr2", 4'b1011, 3, 1);
    step4("shr3", 4'b1000, 3, 1);
    step4("shr4", 4'b1111, 0, 1);

    // Empty mask holds the ID with valid low.
    step4("emp0", 4'b1111, 1, 1);
    step4("emp1", 4'b1111, 2, 1);
    step4("emp2", 4'b0000, 2, 0);
    step4("emp3", 4'b0000, 2, 0);
    step4("emp4", 4'b1111, 3, 1);

    // Reset in mid-rotation restarts the search at thread 0.
    step4("mid0", 4'b1111, 0, 1);
    step4("mid1", 4'b1111, 1, 1);
    step4("mid2", 4'b1111, 2, 1);
    reset4 = 1'b1;
    step4("mid_rst", 4'b1111, 0, 0);
    reset4 = 1'b0;
    step4("mid3", 4'b1111, 0, 1);
    step4("mid4", 4'b1111, 1, 1);
    step4("mid5", 4'b1111, 2, 1);

    // Sparse mask skips inactive threads; a lone thread is granted every cycle.
    step4("spa0", 4'b0101, 0, 1);
    step4("spa1", 4'b0101, 2, 1);
    step4("spa2", 4'b0101, 0, 1);
    step4("spa3", 4'b0101, 2, 1);
    step4("one0", 4'b0100, 2, 1);
    step4("one1", 4'b0100, 2, 1);
    step4("one2", 4'b0100, 2, 1);
    step4("one3", 4'b0001, 0, 1);

    // Non-power-of-two instance: wrap from 4 back to 0, never 5..7.
    reset5 = 1'b0;
    step5("n5_0", 5'b11111, 0);
    step5("n5_1", 5'b11111, 1);
    step5("n5_2", 5'b11111, 2);
    step5("n5_3", 5'b11111, 3);
    step5("n5_4", 5'b11111, 4);
    step5("n5_5", 5'b11111, 0);
    step5("n5_w0", 5'b10001, 4);
    step5("n5_w1", 5'b10001, 0);
    step5("n5_w2", 5'b10001, 4);
    step5("n5_w3", 5'b00110, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
